// File: rtl/axi4lite_simple_bridge.sv
// AXI4-Lite slave to a simple request/ready bus. The read and write paths are
// independent FSMs, each with an alignment check and a ready timeout.
module axi4lite_simple_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
    input  logic                    AXI_AWVALID,
    output logic                    AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
    input  logic                    AXI_WVALID,
    output logic                    AXI_WREADY,
    output logic [1:0]              AXI_BRESP,
    output logic                    AXI_BVALID,
    input  logic                    AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
    input  logic                    AXI_ARVALID,
    output logic                    AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   AXI_RDATA,
    output logic [1:0]              AXI_RRESP,
    output logic                    AXI_RVALID,
    input  logic                    AXI_RREADY,
    output logic                    write,
    output logic [ADDR_WIDTH-1:0]   write_address,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH/8-1:0] write_byteenable,
    input  logic                    write_ready,
    input  logic                    write_address_error,
    input  logic                    write_error,
    output logic                    read,
    output logic [ADDR_WIDTH-1:0]   read_address,
    input  logic                    read_ready,
    input  logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    read_address_error
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_COLLECT, W_ISSUE, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} rstate_t;

    wstate_t                 wst_q;
    logic                    aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic [1:0]              bresp_q;
    logic [7:0]              wcnt_q;

    rstate_t                 rst_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;
    logic [7:0]              rcnt_q;

    logic                    aw_take, w_take, ar_take;
    logic [ADDR_WIDTH-1:0]   awaddr_d;
    logic                    aw_mis, ar_mis;

    assign AXI_AWREADY = (wst_q == W_COLLECT) && !aw_held_q;
    assign AXI_WREADY  = (wst_q == W_COLLECT) && !w_held_q;
    assign AXI_BVALID  = (wst_q == W_RESP);
    assign AXI_BRESP   = bresp_q;
    assign write            = (wst_q == W_ISSUE);
    assign write_address    = awaddr_q;
    assign write_data       = wdata_q;
    assign write_byteenable = wstrb_q;

    assign AXI_ARREADY  = (rst_q == R_IDLE);
    assign AXI_RVALID   = (rst_q == R_RESP);
    assign AXI_RDATA    = rdata_q;
    assign AXI_RRESP    = rresp_q;
    assign read         = (rst_q == R_ISSUE);
    assign read_address = araddr_q;

    assign aw_take  = AXI_AWVALID && AXI_AWREADY;
    assign w_take   = AXI_WVALID && AXI_WREADY;
    assign ar_take  = AXI_ARVALID && AXI_ARREADY;
    // The FSM leaves COLLECT on the edge that completes the pair, so the
    // alignment check must see an address captured on that same edge.
    assign awaddr_d = aw_take ? AXI_AWADDR : awaddr_q;
    assign aw_mis   = |awaddr_d[LSB-1:0];
    assign ar_mis   = |AXI_ARADDR[LSB-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q     <= W_COLLECT;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            wcnt_q    <= '0;
        end else begin
            case (wst_q)
                W_COLLECT: begin
                    if (aw_take) begin
                        awaddr_q  <= AXI_AWADDR;
                        aw_held_q <= 1'b1;
                    end
                    if (w_take) begin
                        wdata_q  <= AXI_WDATA;
                        wstrb_q  <= AXI_WSTRB;
                        w_held_q <= 1'b1;
                    end
                    if ((aw_held_q || aw_take) && (w_held_q || w_take)) begin
                        wcnt_q <= '0;
                        if (aw_mis) begin
                            bresp_q <= RESP_SLVERR;
                            wst_q   <= W_RESP;
                        end else begin
                            wst_q <= W_ISSUE;
                        end
                    end
                end
                W_ISSUE: begin
                    if (write_ready) begin
                        bresp_q <= write_address_error ? RESP_DECERR :
                                   write_error         ? RESP_SLVERR : RESP_OKAY;
                        wst_q   <= W_RESP;
                    end else if (wcnt_q == TO_LAST) begin
                        bresp_q <= RESP_SLVERR;
                        wst_q   <= W_RESP;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                W_RESP: begin
                    if (AXI_BREADY) begin
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        wst_q     <= W_COLLECT;
                    end
                end
                default: wst_q <= W_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_q    <= R_IDLE;
            araddr_q <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rcnt_q   <= '0;
        end else begin
            case (rst_q)
                R_IDLE: begin
                    if (ar_take) begin
                        araddr_q <= AXI_ARADDR;
                        rcnt_q   <= '0;
                        if (ar_mis) begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                            rst_q   <= R_RESP;
                        end else begin
                            rst_q <= R_ISSUE;
                        end
                    end
                end
                R_ISSUE: begin
                    if (read_ready) begin
                        rdata_q <= read_data;
                        rresp_q <= read_address_error ? RESP_DECERR : RESP_OKAY;
                        rst_q   <= R_RESP;
                    end else if (rcnt_q == TO_LAST) begin
                        rdata_q <= '0;
                        rresp_q <= RESP_SLVERR;
                        rst_q   <= R_RESP;
                    end else begin
                        rcnt_q <= rcnt_q + 8'd1;
                    end
                end
                R_RESP: begin
                    if (AXI_RREADY) rst_q <= R_IDLE;
                end
                default: rst_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_simple_bridge.sv
// Directed bench for axi4lite_simple_bridge: a 32-bit instance with a short
// timeout, plus a 64-bit instance used for the wide alignment case.
module tb_axi4lite_simple_bridge;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic            awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [DW-1:0]   wdata = '0, rd_data = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            wr_ready = 0, wr_aerr = 0, wr_err = 0, rd_ready = 0, rd_aerr = 0;

    logic            awready, wready, bvalid, arready, rvalid, wr, rd;
    logic [1:0]      bresp, rresp;
    logic [DW-1:0]   rdata, wr_data;
    logic [AW-1:0]   wr_addr, rd_addr;
    logic [DW/8-1:0] wr_be;

    axi4lite_simple_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
        .write(wr), .write_address(wr_addr), .write_data(wr_data), .write_byteenable(wr_be),
        .write_ready(wr_ready), .write_address_error(wr_aerr), .write_error(wr_err),
        .read(rd), .read_address(rd_addr), .read_ready(rd_ready), .read_data(rd_data),
        .read_address_error(rd_aerr)
    );

    // 64-bit instance: only its read path is driven.
    logic [AW-1:0] ar64_addr = '0;
    logic          ar64_valid = 0;
    logic [63:0]   zero64 = '0;
    logic [7:0]    zero8 = '0;
    logic          awready64, wready64, bvalid64, arready64, rvalid64, wr64, rd64;
    logic [1:0]    bresp64, rresp64;
    logic [63:0]   rdata64, wr_data64;
    logic [AW-1:0] wr_addr64, rd_addr64;
    logic [7:0]    wr_be64;

    axi4lite_simple_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(64), .TIMEOUT_CYCLES(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .AXI_AWADDR(ar64_addr), .AXI_AWVALID(1'b0), .AXI_AWREADY(awready64),
        .AXI_WDATA(zero64), .AXI_WSTRB(zero8), .AXI_WVALID(1'b0), .AXI_WREADY(wready64),
        .AXI_BRESP(bresp64), .AXI_BVALID(bvalid64), .AXI_BREADY(1'b0),
        .AXI_ARADDR(ar64_addr), .AXI_ARVALID(ar64_valid), .AXI_ARREADY(arready64),
        .AXI_RDATA(rdata64), .AXI_RRESP(rresp64), .AXI_RVALID(rvalid64), .AXI_RREADY(rready),
        .write(wr64), .write_address(wr_addr64), .write_data(wr_data64), .write_byteenable(wr_be64),
        .write_ready(1'b0), .write_address_error(1'b0), .write_error(1'b0),
        .read(rd64), .read_address(rd_addr64), .read_ready(1'b0), .read_data(zero64),
        .read_address_error(1'b0)
    );

    int errors = 0;
    int checks = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int rd64_pulses = 0;
    int base;

    always @(posedge clk) begin
        if (wr)   wr_pulses   <= wr_pulses + 1;
        if (rd)   rd_pulses   <= rd_pulses + 1;
        if (rd64) rd64_pulses <= rd64_pulses + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_write", wr, 0);
        chk("rst_read", rd, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 1);
        chk("post_rst_arready", arready, 1);

        // AW first, W three cycles later, immediate write_ready
        wr_ready = 1;
        awaddr = 32'h100; awvalid = 1;
        tick();
        awvalid = 0;
        chk("aw_held_awready", awready, 0);
        chk("aw_held_wready", wready, 1);
        chk("aw_only_no_write", wr, 0);
        tick(); tick();
        base = wr_pulses;
        wdata = 32'hDEADBEEF; wstrb = 4'b1010; wvalid = 1;
        tick();
        wvalid = 0;
        chk("wr1_write", wr, 1);
        chk("wr1_addr", wr_addr, 32'h100);
        chk("wr1_data", wr_data, 32'hDEADBEEF);
        chk("wr1_be", wr_be, 4'b1010);
        chk("wr1_issue_awready", awready, 0);
        tick();
        chk("wr1_bvalid", bvalid, 1);
        chk("wr1_bresp", bresp, 2'b00);
        chk("wr1_write_dropped", wr, 0);
        tick(); tick();
        chk("wr1_bvalid_held", bvalid, 1);
        chk("wr1_pulses", wr_pulses - base, 1);
        bready = 1;
        tick();
        bready = 0;
        chk("wr1_bvalid_clr", bvalid, 0);
        chk("wr1_awready_back", awready, 1);

        // concurrent read and write, read_ready after 2 cycles
        aw_w(32'h80, 32'h12345678, 4'hF);
        araddr = 32'h40; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("cc_write", wr, 1);
        chk("cc_read", rd, 1);
        chk("cc_read_addr", rd_addr, 32'h40);
        tick();
        chk("cc_bvalid", bvalid, 1);
        chk("cc_bresp", bresp, 2'b00);
        chk("cc_read_still", rd, 1);
        rd_ready = 1; rd_data = 32'hCAFEF00D;
        tick();
        rd_ready = 0;
        chk("cc_rvalid", rvalid, 1);
        chk("cc_rdata", rdata, 32'hCAFEF00D);
        chk("cc_rresp", rresp, 2'b00);
        chk("cc_read_dropped", rd, 0);
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        chk("cc_both_idle", {bvalid, rvalid}, 0);

        // misaligned accesses
        base = wr_pulses;
        aw_w(32'h2, 32'h11111111, 4'hF);
        araddr = 32'h2; arvalid = 1;
        ar64_addr = 32'h4; ar64_valid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0; ar64_valid = 0;
        chk("mis_no_write", wr, 0);
        chk("mis_bvalid", bvalid, 1);
        chk("mis_bresp", bresp, 2'b10);
        chk("mis_no_read", rd, 0);
        chk("mis_rvalid", rvalid, 1);
        chk("mis_rresp", rresp, 2'b10);
        chk("mis_rdata", rdata, 0);
        chk("mis64_no_read", rd64_pulses, 0);
        chk("mis64_rvalid", rvalid64, 1);
        chk("mis64_rresp", rresp64, 2'b10);
        chk("mis64_rdata", rdata64, 0);
        tick();
        chk("mis_write_pulses", wr_pulses - base, 0);
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;

        // read timeout
        base = rd_pulses;
        araddr = 32'h10; arvalid = 1;
        tick();
        arvalid = 0;
        for (int i = 0; i < 20 && !rvalid; i++) tick();
        chk("rto_read_cycles", rd_pulses - base, 4);
        chk("rto_rvalid", rvalid, 1);
        chk("rto_rresp", rresp, 2'b10);
        chk("rto_rdata", rdata, 0);
        rready = 1;
        tick();
        rready = 0;

        // ready on the 4th issue cycle wins over the timeout
        araddr = 32'h14; arvalid = 1;
        tick();
        arvalid = 0;
        tick(); tick(); tick();
        chk("r4_still_read", rd, 1);
        rd_ready = 1; rd_data = 32'h55AA55AA;
        tick();
        rd_ready = 0;
        chk("r4_rvalid", rvalid, 1);
        chk("r4_rresp", rresp, 2'b00);
        chk("r4_rdata", rdata, 32'h55AA55AA);
        rready = 1;
        tick();
        rready = 0;

        // write error encodings
        wr_aerr = 1; wr_err = 1;
        aw_w(32'h200, 32'hA5A5A5A5, 4'h3);
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        chk("werr_both_bresp", bresp, 2'b11);
        bready = 1; tick(); bready = 0;
        wr_aerr = 0;
        aw_w(32'h204, 32'h5A5A5A5A, 4'hC);
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        chk("werr_err_bresp", bresp, 2'b10);
        bready = 1; tick(); bready = 0;
        wr_err = 0;

        // read response held while RREADY stays low
        araddr = 32'h20; arvalid = 1;
        tick();
        arvalid = 0;
        rd_ready = 1; rd_data = 32'h0BADF00D; rd_aerr = 1;
        tick();
        rd_ready = 0; rd_data = 32'hFFFFFFFF; rd_aerr = 0;
        repeat (10) tick();
        chk("hold_rvalid", rvalid, 1);
        chk("hold_rdata", rdata, 32'h0BADF00D);
        chk("hold_rresp", rresp, 2'b11);
        rready = 1; tick(); rready = 0;

        // write timeout
        wr_ready = 0;
        aw_w(32'h300, 32'h0, 4'hF);
        tick();
        awvalid = 0; wvalid = 0;
        base = wr_pulses;
        for (int i = 0; i < 20 && !bvalid; i++) tick();
        chk("wto_write_cycles", wr_pulses - base, 4);
        chk("wto_bresp", bresp, 2'b10);
        bready = 1; tick(); bready = 0;

        // reset during W_ISSUE
        aw_w(32'h400, 32'h77777777, 4'hF);
        tick();
        awvalid = 0; wvalid = 0;
        chk("rstmid_write", wr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_write_drop", wr, 0);
        chk("rstmid_bvalid", bvalid, 0);
        #1 rst_n = 1'b1;
        tick();
        chk("rstmid_ready", {awready, wready, arready}, 3'b111);
        chk("rstmid_no_bvalid", bvalid, 0);
        wr_ready = 1;
        aw_w(32'h500, 32'h13579BDF, 4'hF);
        tick();
        awvalid = 0; wvalid = 0;
        chk("after_rst_write", wr, 1);
        chk("after_rst_addr", wr_addr, 32'h500);
        chk("after_rst_data", wr_data, 32'h13579BDF);
        tick();
        chk("after_rst_bvalid", bvalid, 1);
        chk("after_rst_bresp", bresp, 2'b00);
        bready = 1; tick(); bready = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi4lite_simple_bridge.md
AXI4LITE_SIMPLE_BRIDGE -- requirements
Module: axi4lite_simple_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, legal values 32 or 64; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, range 1..255; cycles allowed for a simple-side ready.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports as below.
REQ-005 SHALL have the following ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel
- AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  write data channel
- AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
- AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1  read address channel
- AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
- write / write_address / write_data / write_byteenable  out  1/ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH  simple write request, held stable while write=1
- write_ready  in  1  simple slave accepts write this cycle
- write_address_error / write_error  in  1/1  sampled only when write & write_ready
- read / read_address  out  1/ADDR_WIDTH  simple read request, held stable while read=1
- read_ready  in  1  read_data valid this cycle
- read_data / read_address_error  in  DATA_WIDTH/1  sampled only when read & read_ready

Function
REQ-006 Read and write paths SHALL be independent FSMs running concurrently; no arbitration between them.
REQ-007 All AXI outputs and write/read SHALL be driven from registers or decoded from state only; no combinational path from any input to any output.
REQ-008 Write FSM states: W_COLLECT, W_ISSUE, W_RESP.
REQ-009 W_COLLECT: AWREADY = !aw_held, WREADY = !w_held; AW and W captured independently into holding registers in any order or same cycle; when both held, next cycle SHALL enter W_ISSUE, or W_RESP directly if misaligned.
REQ-010 Misaligned = any of the low log2(STRB_WIDTH) bits of captured address nonzero; misaligned accesses SHALL NOT assert write/read and SHALL respond SLVERR (2'b10).
REQ-011 W_ISSUE: write=1 with held address/data/strobe; on write_ready, BRESP captured (write_address_error -> 2'b11 DECERR, else write_error -> 2'b10, else 2'b00), go to W_RESP.
REQ-012 W_RESP: BVALID=1, BRESP stable; on BREADY, clear aw_held/w_held, return to W_COLLECT; AWREADY/WREADY SHALL be 0 in W_ISSUE and W_RESP.
REQ-013 Read FSM states: R_IDLE (ARREADY=1), R_ISSUE, R_RESP; AR handshake captures ARADDR and goes to R_ISSUE, or R_RESP if misaligned with RDATA=0.
REQ-014 R_ISSUE: read=1; on read_ready capture read_data into RDATA, RRESP = read_address_error ? 2'b11 : 2'b00, go to R_RESP.
REQ-015 R_RESP: RVALID=1, RDATA/RRESP stable until RREADY, then R_IDLE.
REQ-016 Each path SHALL have an 8-bit timeout counter cleared on entering ISSUE, incremented each ISSUE cycle without ready; when it reaches TIMEOUT_CYCLES, drop write/read, respond 2'b10 (RDATA=0), go to RESP.
REQ-017 Ready arriving on the same cycle the counter reaches TIMEOUT_CYCLES SHALL take precedence (normal response).
REQ-018 Throughput: one transaction per path per 3 cycles minimum (handshake, issue with immediate ready, response with immediate ready).

Reset
REQ-019 On rst_n low, immediately: both FSMs to COLLECT/IDLE, aw_held=w_held=0, counters 0, BVALID=RVALID=write=read=0, BRESP=RRESP=0, RDATA=0.
REQ-020 Reset asserted mid-transaction SHALL abandon it with no response; AWREADY=WREADY=ARREADY=1 in first cycle after deassertion.

Verification
REQ-021 AW at cycle 0, W at cycle 3, write_ready immediate, no errors -> one write pulse with correct address/data/strobe, BRESP=00, BVALID held until BREADY.
REQ-022 Concurrent AR and AW+W in the same cycle, read_ready after 2 cycles -> both complete independently, RDATA equals read_data, RRESP=00, BRESP=00.
REQ-023 AWADDR=0x2 (DATA_WIDTH=32) and ARADDR=0x4 with DATA_WIDTH=64 -> no write/read pulse, BRESP=10, RRESP=10, RDATA=0.
REQ-024 read_ready never asserted, TIMEOUT_CYCLES=4 -> read high exactly 4 cycles, then RVALID with RRESP=10; read_ready on 4th cycle instead -> RRESP=00.
REQ-025 write_address_error and write_error both 1 -> BRESP=11; write_error only -> BRESP=10; RREADY held low 10 cycles -> RDATA/RRESP unchanged.
REQ-026 rst_n pulsed low during W_ISSUE -> write drops asynchronously, no BVALID, next AW+W completes normally.
